// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation: NOP wait, PRECHARGE ALL, NUM_REFRESH auto-refreshes, MRS, then done.
// All outputs registered from the next state, so each command appears in the same cycle as its state.
module sdram_init_seq #(
   parameter int PWRUP_CYCLES = 10000,
   parameter int TRP          = 3,
   parameter int TRFC         = 7,
   parameter int NUM_REFRESH  = 8,
   parameter int TMRD         = 2
) (
   input  logic        sdram_clk,
   input  logic        sdram_resetn,
   input  logic        init_req,
   input  logic [12:0] cfg_mode_reg,
   output logic        sdr_cke,
   output logic        sdr_cs_n,
   output logic        sdr_ras_n,
   output logic        sdr_cas_n,
   output logic        sdr_we_n,
   output logic [12:0] sdr_addr,
   output logic [1:0]  sdr_ba,
   output logic        sdram_init_done,
   output logic [2:0]  init_state
);

   typedef enum logic [2:0] {
      PWRUP     = 3'd0,
      PRE       = 3'd1,
      WAIT_TRP  = 3'd2,
      REF       = 3'd3,
      WAIT_TRFC = 3'd4,
      MRS       = 3'd5,
      WAIT_MRD  = 3'd6,
      DONE      = 3'd7
   } state_t;

   localparam int PW_BITS = ($clog2(PWRUP_CYCLES + 1) > 16) ? $clog2(PWRUP_CYCLES + 1) : 16;
   localparam logic [PW_BITS-1:0] PWR_TC  = PW_BITS'(PWRUP_CYCLES);
   localparam logic [PW_BITS-1:0] PWR_ONE = PW_BITS'(1);
   localparam logic [3:0] NUM_R   = 4'(NUM_REFRESH);
   // Wait counters hold "remaining wait cycles after this one"
   localparam logic [3:0] TRP_LD  = 4'((TRP  >= 2) ? TRP  - 2 : 0);
   localparam logic [3:0] TRFC_LD = 4'((TRFC >= 2) ? TRFC - 2 : 0);
   localparam logic [3:0] TMRD_LD = 4'((TMRD >= 2) ? TMRD - 2 : 0);

   state_t               state, nxt;
   logic [PW_BITS-1:0]   pwr_cnt, pwr_cnt_nxt;
   logic [3:0]           dly, dly_nxt;
   logic [3:0]           ref_cnt, ref_cnt_nxt;
   logic                 done_seen;

   always_comb begin
      nxt         = state;
      pwr_cnt_nxt = pwr_cnt;
      dly_nxt     = dly;
      ref_cnt_nxt = ref_cnt;
      case (state)
         PWRUP: begin
            ref_cnt_nxt = 4'd0;
            if (pwr_cnt == PWR_TC) nxt = PRE;
            else                   pwr_cnt_nxt = pwr_cnt + PWR_ONE;
         end
         PRE: begin
            if (TRP == 1) begin
               nxt         = REF;
               ref_cnt_nxt = ref_cnt + 4'd1;
            end else begin
               nxt     = WAIT_TRP;
               dly_nxt = TRP_LD;
            end
         end
         WAIT_TRP: begin
            if (dly == 4'd0) begin
               nxt         = REF;
               ref_cnt_nxt = ref_cnt + 4'd1;
            end else begin
               dly_nxt = dly - 4'd1;
            end
         end
         REF, WAIT_TRFC: begin
            if (state == REF && TRFC != 1) begin
               nxt     = WAIT_TRFC;
               dly_nxt = TRFC_LD;
            end else if (state == WAIT_TRFC && dly != 4'd0) begin
               dly_nxt = dly - 4'd1;
            end else if (ref_cnt == NUM_R) begin
               nxt = MRS;
            end else begin
               nxt         = REF;
               ref_cnt_nxt = ref_cnt + 4'd1;
            end
         end
         MRS: begin
            if (TMRD == 1) begin
               nxt = DONE;
            end else begin
               nxt     = WAIT_MRD;
               dly_nxt = TMRD_LD;
            end
         end
         WAIT_MRD: begin
            if (dly == 4'd0) nxt = DONE;
            else             dly_nxt = dly - 4'd1;
         end
         DONE: begin
            // pwr_cnt is still saturated, so PWRUP lasts exactly one NOP cycle
            if (init_req && done_seen) nxt = PWRUP;
         end
         default: nxt = PWRUP;
      endcase
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state     <= PWRUP;
         pwr_cnt   <= '0;
         dly       <= 4'd0;
         ref_cnt   <= 4'd0;
         done_seen <= 1'b0;
      end else begin
         state     <= nxt;
         pwr_cnt   <= pwr_cnt_nxt;
         dly       <= dly_nxt;
         ref_cnt   <= ref_cnt_nxt;
         done_seen <= (state == DONE);
      end
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         sdr_cke                                   <= 1'b0;
         {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b1111;
         sdr_addr                                  <= 13'd0;
         sdr_ba                                    <= 2'd0;
         sdram_init_done                           <= 1'b0;
      end else begin
         sdr_cke         <= 1'b1;
         sdr_ba          <= 2'd0;
         sdram_init_done <= (nxt == DONE);
         case (nxt)
            PRE: begin
               {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b0010;
               sdr_addr                                  <= 13'h0400;
            end
            REF: begin
               {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b0001;
               sdr_addr                                  <= 13'd0;
            end
            MRS: begin
               {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b0000;
               sdr_addr                                  <= cfg_mode_reg;
            end
            default: begin
               {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b0111;
               sdr_addr                                  <= 13'd0;
            end
         endcase
      end
   end

   assign init_state = state;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: cycle-accurate arithmetic reference model on the default
// instance, plus a vector table on a minimal-timing instance.
module tb_sdram_init_seq;

   localparam int PWR = 10000, TRP = 3, TRFC = 7, NREF = 8, TMRD = 2;
   localparam int M_CYC  = TRP + NREF * TRFC;   // MRS offset from PRECHARGE
   localparam int DN_CYC = M_CYC + TMRD;        // first done offset

   logic        clk;
   logic        sdram_resetn;
   logic        big_req, min_req;
   logic [12:0] big_cfg, min_cfg;

   logic        b_cke, b_cs, b_ras, b_cas, b_we, b_done;
   logic [12:0] b_addr;
   logic [1:0]  b_ba;
   logic [2:0]  b_st;
   logic        m_cke, m_cs, m_ras, m_cas, m_we, m_done;
   logic [12:0] m_addr;
   logic [1:0]  m_ba;
   logic [2:0]  m_st;

   int n_chk = 0, n_fail = 0;
   int cyc, pre_cyc;
   bit rnd_en, req_prev;

   sdram_init_seq dut (
      .sdram_clk(clk), .sdram_resetn(sdram_resetn), .init_req(big_req), .cfg_mode_reg(big_cfg),
      .sdr_cke(b_cke), .sdr_cs_n(b_cs), .sdr_ras_n(b_ras), .sdr_cas_n(b_cas), .sdr_we_n(b_we),
      .sdr_addr(b_addr), .sdr_ba(b_ba), .sdram_init_done(b_done), .init_state(b_st)
   );

   sdram_init_seq #(.PWRUP_CYCLES(4), .TRP(1), .TRFC(1), .NUM_REFRESH(1), .TMRD(1)) dut_min (
      .sdram_clk(clk), .sdram_resetn(sdram_resetn), .init_req(min_req), .cfg_mode_reg(min_cfg),
      .sdr_cke(m_cke), .sdr_cs_n(m_cs), .sdr_ras_n(m_ras), .sdr_cas_n(m_cas), .sdr_we_n(m_we),
      .sdr_addr(m_addr), .sdr_ba(m_ba), .sdram_init_done(m_done), .init_state(m_st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {cke, cmd[3:0], addr[12:0], ba[1:0], done, state[2:0]}
   wire [23:0] b_obs = {b_cke, b_cs, b_ras, b_cas, b_we, b_addr, b_ba, b_done, b_st};
   wire [23:0] m_obs = {m_cke, m_cs, m_ras, m_cas, m_we, m_addr, m_ba, m_done, m_st};
   wire [3:0]  b_cmd = {b_cs, b_ras, b_cas, b_we};
   localparam logic [23:0] RST_OBS = {1'b0, 4'b1111, 13'd0, 2'd0, 1'b0, 3'd0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
      end
   endtask

   // Expected outputs at offset rel from the PRECHARGE cycle
   function automatic logic [23:0] model_out(input int rel, input logic [12:0] cfg);
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic        dn;
      logic [2:0]  st;
      cmd = 4'b0111; addr = 13'd0; dn = 1'b0; st = 3'd0;
      if (rel < 0)             st = 3'd0;
      else if (rel == 0)       begin cmd = 4'b0010; addr = 13'h0400; st = 3'd1; end
      else if (rel < TRP)      st = 3'd2;
      else if (rel < M_CYC)    begin
         if ((rel - TRP) % TRFC == 0) begin cmd = 4'b0001; st = 3'd3; end
         else st = 3'd4;
      end
      else if (rel == M_CYC)   begin cmd = 4'b0000; addr = cfg; st = 3'd5; end
      else if (rel < DN_CYC)   st = 3'd6;
      else                     begin dn = 1'b1; st = 3'd7; end
      return {1'b1, cmd, addr, 2'd0, dn, st};
   endfunction

   task automatic run_big(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req_prev = big_req;
         cyc++;
         // a request is accepted only after the first done cycle has passed
         if (req_prev && ((cyc - 1) - pre_cyc) > DN_CYC) pre_cyc = cyc + 1;
         chk("model", {8'd0, b_obs}, {8'd0, model_out(cyc - pre_cyc, big_cfg)});
         big_req = rnd_en ? ($urandom_range(0, 15) == 0) : 1'b0;
      end
   endtask

   typedef struct {
      logic        req;
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic        done;
      logic [2:0]  st;
   } vec_t;
   vec_t tbl[16];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // cycles 1..16 of the minimal instance; req is driven during that cycle
      tbl[0]  = '{1'b0, 4'b0111, 13'h0000, 1'b0, 3'd0};
      tbl[1]  = '{1'b1, 4'b0111, 13'h0000, 1'b0, 3'd0};
      tbl[2]  = '{1'b0, 4'b0111, 13'h0000, 1'b0, 3'd0};
      tbl[3]  = '{1'b0, 4'b0111, 13'h0000, 1'b0, 3'd0};
      tbl[4]  = '{1'b0, 4'b0010, 13'h0400, 1'b0, 3'd1};
      tbl[5]  = '{1'b1, 4'b0001, 13'h0000, 1'b0, 3'd3};
      tbl[6]  = '{1'b0, 4'b0000, 13'h1abc, 1'b0, 3'd5};
      tbl[7]  = '{1'b1, 4'b0111, 13'h0000, 1'b1, 3'd7};
      tbl[8]  = '{1'b1, 4'b0111, 13'h0000, 1'b1, 3'd7};
      tbl[9]  = '{1'b0, 4'b0111, 13'h0000, 1'b0, 3'd0};
      tbl[10] = '{1'b0, 4'b0010, 13'h0400, 1'b0, 3'd1};
      tbl[11] = '{1'b0, 4'b0001, 13'h0000, 1'b0, 3'd3};
      tbl[12] = '{1'b0, 4'b0000, 13'h1abc, 1'b0, 3'd5};
      tbl[13] = '{1'b0, 4'b0111, 13'h0000, 1'b1, 3'd7};
      tbl[14] = '{1'b1, 4'b0111, 13'h0000, 1'b1, 3'd7};
      tbl[15] = '{1'b0, 4'b0111, 13'h0000, 1'b0, 3'd0};

      big_req = 1'b0; min_req = 1'b0;
      big_cfg = 13'h0033; min_cfg = 13'h1abc;
      rnd_en = 1'b0; cyc = 0;
      sdram_resetn = 1'b1;
      #1 sdram_resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_big", {8'd0, b_obs}, {8'd0, RST_OBS});
      chk("reset_min", {8'd0, m_obs}, {8'd0, RST_OBS});
      #2 sdram_resetn = 1'b1;

      fork
         begin
            for (int k = 0; k < 16; k++) begin
               @(posedge clk);
               #1;
               chk($sformatf("min_vec%0d", k + 1), {8'd0, m_obs},
                   {8'd0, 1'b1, tbl[k].cmd, tbl[k].addr, 2'd0, tbl[k].done, tbl[k].st});
               min_req = tbl[k].req;
            end
            min_req = 1'b0;
         end
         begin
            cyc = 0; pre_cyc = PWR + 1; rnd_en = 1'b1;
            run_big(10000);
            chk("pwrup_last_nop", b_cmd, 4'b0111);
            rnd_en = 1'b0;
            run_big(1);
            chk("pre_10001", {b_cmd, b_addr}, {4'b0010, 13'h0400});
            run_big(3);
            chk("ref0_10004", b_cmd, 4'b0001);
            run_big(1);
            chk("wait_trfc_state", b_st, 3'd4);
            big_req = 1'b1;                      // ignored: not in DONE
            run_big(48);
            chk("ref7_10053", b_cmd, 4'b0001);
            run_big(7);
            chk("mrs_10060", {b_cmd, b_addr, b_ba}, {4'b0000, 13'h0033, 2'd0});
            run_big(1);
            chk("done_low_10061", b_done, 1'b0);
            run_big(1);
            chk("done_10062", {b_done, b_st}, {1'b1, 3'd7});
            big_req = 1'b1;                      // coincident with done rising: ignored
            run_big(1);
            chk("req_first_done_ignored", b_done, 1'b1);
            run_big(4);
            big_req = 1'b1;                      // cycle D = 10067
            run_big(1);
            chk("reinit_done_low", {b_done, b_cmd}, {1'b0, 4'b0111});
            run_big(1);
            chk("reinit_pre", b_cmd, 4'b0010);
            run_big(59);
            chk("reinit_mrs", b_cmd, 4'b0000);
            run_big(1);
            chk("reinit_done_d62", b_done, 1'b0);
            run_big(1);
            chk("reinit_done_d63", b_done, 1'b1);
            rnd_en = 1'b1;
            run_big(600);
            rnd_en = 1'b0;
            big_req = 1'b0;
         end
      join

      // reset while running, then mid-sequence reset at cycle 10020
      sdram_resetn = 1'b0;
      #1;
      chk("async_reset_big", {8'd0, b_obs}, {8'd0, RST_OBS});
      chk("async_reset_min", {8'd0, m_obs}, {8'd0, RST_OBS});
      repeat (2) @(posedge clk);
      #3 sdram_resetn = 1'b1;
      cyc = 0; pre_cyc = PWR + 1;
      run_big(10020);
      sdram_resetn = 1'b0;
      #1;
      chk("midreset_bus", {b_cke, b_cmd, b_addr, b_ba, b_done, b_st}, {1'b0, 4'b1111, 13'd0, 2'd0, 1'b0, 3'd0});
      @(posedge clk);
      #1;
      chk("midreset_hold", {8'd0, b_obs}, {8'd0, RST_OBS});
      #2 sdram_resetn = 1'b1;
      cyc = 0; pre_cyc = PWR + 1;
      run_big(10000);
      chk("restart_nop", {b_cke, b_cmd}, {1'b1, 4'b0111});
      run_big(1);
      chk("restart_pre", b_cmd, 4'b0010);
      run_big(70);
      chk("restart_done", b_done, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_init_seq.md
SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 The module SHALL have parameter PWRUP_CYCLES, default 10000, giving the number of power-up NOP cycles after reset release.
REQ-002 The module SHALL have parameter TRP, default 3, giving the precharge-to-next-command spacing in cycles (legal range 1..15).
REQ-003 The module SHALL have parameter TRFC, default 7, giving the refresh-to-next-command spacing in cycles (legal range 1..15).
REQ-004 The module SHALL have parameter NUM_REFRESH, default 8, giving the auto-refresh count (legal range 1..15).
REQ-005 The module SHALL have parameter TMRD, default 2, giving the mode-register-set to done spacing in cycles (legal range 1..15).
REQ-006 Port sdram_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 Port sdram_resetn  in  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-008 Port init_req  in  1  SHALL be a single-cycle pulse requesting re-initialisation.
REQ-009 Port cfg_mode_reg  in  13  SHALL supply the mode-register value, sampled in the MRS cycle.
REQ-010 Port sdr_cke  out  1  SHALL be the SDRAM clock enable.
REQ-011 Ports sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  out  1 each  SHALL form the command bus.
REQ-012 Port sdr_addr  out  13  SHALL be the address bus, and port sdr_ba  out  2  SHALL be the bank address.
REQ-013 Port sdram_init_done  out  1  SHALL be high only while the SDRAM is initialised.
REQ-014 Port init_state  out  3  SHALL expose the current FSM state for debug.

Function
REQ-015 The FSM SHALL have the states PWRUP, PRE, WAIT_TRP, REF, WAIT_TRFC, MRS, WAIT_MRD and DONE, encoded 0..7 in that order on init_state.
REQ-016 The command encodings (cs_n, ras_n, cas_n, we_n) SHALL be: NOP 0111, PRECHARGE 0010 with sdr_addr[10]=1, AUTO REFRESH 0001, MRS 0000 with sdr_ba=0 and sdr_addr=cfg_mode_reg.
REQ-017 Each non-NOP command SHALL be driven for exactly one cycle; every other post-reset cycle SHALL be NOP, with sdr_addr=0 and sdr_ba=0.
REQ-018 Cycle numbering: cycle 1 SHALL be the first rising edge after sdram_resetn deasserts, and outputs SHALL be registered.
REQ-019 Cycles 1..PWRUP_CYCLES SHALL be NOP with sdr_cke=1.
REQ-020 PRECHARGE SHALL be issued at cycle P = PWRUP_CYCLES+1.
REQ-021 AUTO REFRESH number i (i = 0..NUM_REFRESH-1) SHALL be issued at cycle P+TRP+i*TRFC.
REQ-022 MRS SHALL be issued at cycle P+TRP+NUM_REFRESH*TRFC.
REQ-023 sdram_init_done SHALL rise at cycle P+TRP+NUM_REFRESH*TRFC+TMRD and stay high until reset or an accepted init_req.
REQ-024 The power-up counter SHALL be at least 16 bits wide, and the refresh counter SHALL be 4 bits wide.
REQ-025 Counters SHALL never wrap: the power-up counter SHALL saturate at terminal count, and the refresh counter SHALL stop at NUM_REFRESH.
REQ-026 init_req in DONE SHALL drive sdram_init_done low on the next cycle, then one NOP cycle, then PRECHARGE.
REQ-027 After a DONE-state init_req, the sequence SHALL follow REQ-021..REQ-023 relative to the new PRECHARGE, with no power-up wait.
REQ-028 init_req in any state other than DONE SHALL be ignored.
REQ-029 init_req coincident with the cycle sdram_init_done rises SHALL be ignored.
REQ-030 In DONE the module SHALL drive NOP continuously (command-bus ownership passes to the controller via sdram_init_done).

Reset
REQ-031 While sdram_resetn=0, sdr_cke SHALL be 0.
REQ-032 While sdram_resetn=0, sdr_cs_n, sdr_ras_n, sdr_cas_n and sdr_we_n SHALL each be 1 (DESELECT).
REQ-033 While sdram_resetn=0, sdr_addr SHALL be 0 and sdr_ba SHALL be 0.
REQ-034 While sdram_resetn=0, sdram_init_done SHALL be 0 and init_state SHALL be 0 (PWRUP).
REQ-035 Reset asserted mid-sequence SHALL abort immediately (asynchronously), and the full sequence, including power-up, SHALL restart on release.

Verification
REQ-036 Defaults, reset released -> NOP cycles 1..10000, PRECHARGE at 10001 with addr[10]=1, REF at 10004, 10011, ..., 10053 (8 total), MRS at 10060, init_done rises at 10062.
REQ-037 cfg_mode_reg=13'h0033 -> the MRS cycle shows sdr_addr=13'h0033, sdr_ba=0 and command 0000.
REQ-038 init_req pulse 5 cycles after done, at cycle D -> init_done=0 at D+1, PRECHARGE at D+2, MRS at D+2+3+56, init_done high at D+63.
REQ-039 init_req during WAIT_TRFC -> no change to REF timing or count, and init_done timing matches REQ-036.
REQ-040 sdram_resetn pulsed low at cycle 10020 -> command bus reads 1111 and cke=0 immediately, then after release NOP restarts and PRECHARGE comes 10001 cycles later.
REQ-041 PWRUP_CYCLES=4, TRP=1, TRFC=1, NUM_REFRESH=1, TMRD=1 -> PRE at 5, REF at 6, MRS at 7, init_done at 8, with no cycle between commands.
